// File: rtl/ahb_lite_cordic_master.sv
// AHB-Lite master that turns a local command/response stream into single
// write/read transfers against the CORDIC slave. One transfer is in flight at a time.
module ahb_lite_cordic_master #(
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
  parameter logic [31:0] RESULT_OFFSET = 32'h0000_0004,
  parameter logic [15:0] MAX_WAIT      = 16'd255
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        timeout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

  localparam logic [31:0] READ_ADDR    = BASE_ADDR + RESULT_OFFSET;
  localparam logic [1:0]  TRANS_IDLE   = 2'b00;
  localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
  localparam logic [1:0]  OP_WRITE     = 2'b01;
  localparam logic [1:0]  OP_READ      = 2'b10;

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA, RESP} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_reg, op_next;
  logic [31:0] operand_reg, operand_next;
  logic [15:0] stall_reg, stall_next;
  logic [31:0] haddr_reg, haddr_next;
  logic [1:0]  htrans_reg, htrans_next;
  logic        hwrite_reg, hwrite_next;
  logic [31:0] hwdata_reg, hwdata_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_data_reg, rsp_data_next;
  logic        rsp_err_reg, rsp_err_next;
  logic        timeout_reg, timeout_next;
  logic        cmd_ready_reg;
  logic        bus_state;

  assign bus_state = (state_reg == W_ADDR) || (state_reg == W_DATA) ||
                     (state_reg == R_ADDR) || (state_reg == R_DATA);

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    operand_next   = operand_reg;
    stall_next     = stall_reg;
    haddr_next     = haddr_reg;
    htrans_next    = TRANS_IDLE;
    hwrite_next    = hwrite_reg;
    hwdata_next    = hwdata_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;
    timeout_next   = timeout_reg;

    // Stall counter only measures the slave holding off a live transfer.
    if (HREADY) begin
      stall_next = 16'd0;
    end else if (bus_state && (stall_reg != MAX_WAIT)) begin
      stall_next = stall_reg + 16'd1;
    end
    if (bus_state && !HREADY && (stall_next == MAX_WAIT)) begin
      timeout_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          op_next       = cmd_op;
          operand_next  = cmd_data;
          rsp_data_next = 32'd0;
          rsp_err_next  = 1'b0;
          timeout_next  = 1'b0;
          stall_next    = 16'd0;
          htrans_next   = TRANS_NONSEQ;
          if (cmd_op == OP_READ) begin
            state_next  = R_ADDR;
            haddr_next  = READ_ADDR;
            hwrite_next = 1'b0;
          end else begin
            state_next  = W_ADDR;
            haddr_next  = BASE_ADDR;
            hwrite_next = 1'b1;
          end
        end
      end
      W_ADDR: begin
        if (HREADY) begin
          state_next  = W_DATA;
          hwdata_next = operand_reg;
        end else begin
          htrans_next = TRANS_NONSEQ;
        end
      end
      W_DATA: begin
        if (HREADY) begin
          if (HRESP) begin
            rsp_err_next   = 1'b1;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else if (op_reg == OP_WRITE) begin
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else begin
            state_next  = R_ADDR;
            htrans_next = TRANS_NONSEQ;
            haddr_next  = READ_ADDR;
            hwrite_next = 1'b0;
          end
        end
      end
      R_ADDR: begin
        if (HREADY) begin
          state_next = R_DATA;
        end else begin
          htrans_next = TRANS_NONSEQ;
        end
      end
      R_DATA: begin
        if (HREADY) begin
          rsp_data_next  = HRESP ? 32'd0 : HRDATA;
          rsp_err_next   = rsp_err_reg | HRESP;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          rsp_valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_reg     <= IDLE;
      op_reg        <= 2'b00;
      operand_reg   <= 32'd0;
      stall_reg     <= 16'd0;
      haddr_reg     <= 32'd0;
      htrans_reg    <= TRANS_IDLE;
      hwrite_reg    <= 1'b0;
      hwdata_reg    <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 32'd0;
      rsp_err_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
      cmd_ready_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      operand_reg   <= operand_next;
      stall_reg     <= stall_next;
      haddr_reg     <= haddr_next;
      htrans_reg    <= htrans_next;
      hwrite_reg    <= hwrite_next;
      hwdata_reg    <= hwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      timeout_reg   <= timeout_next;
      cmd_ready_reg <= (state_next == IDLE);
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign timeout   = timeout_reg;
  assign HADDR     = haddr_reg;
  assign HTRANS    = htrans_reg;
  assign HWRITE    = hwrite_reg;
  assign HWDATA    = hwdata_reg;
  assign HSIZE     = 3'b010;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;

endmodule

// File: tb/tb_ahb_lite_cordic_master.sv
// Bench for ahb_lite_cordic_master: table of commands against a scripted
// zero/multi-wait slave, scoreboard of expected responses, plus reset and backpressure sequences.
module tb_ahb_lite_cordic_master;

  localparam logic [31:0] WADDR = 32'h4000_0000;
  localparam logic [31:0] RADDR = 32'h4000_0004;
  localparam int          TB_MAX_WAIT = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        timeout;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [31:0] HRDATA = 32'd0;

  always #5 HCLK = ~HCLK;

  ahb_lite_cordic_master #(
    .BASE_ADDR(32'h4000_0000),
    .RESULT_OFFSET(32'h0000_0004),
    .MAX_WAIT(16'd4)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .timeout(timeout),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] rdata;
    int          w_aw, w_dw, r_aw, r_dw;
    bit          w_err, r_err;
    int          hold;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
    bit          exp_to;
    int          exp_wr, exp_rd;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          lat;
    bit          to;
    int          wr, rd;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] data, input logic [31:0] rdata,
                              input int w_aw, input int w_dw, input int r_aw, input int r_dw,
                              input bit w_err, input bit r_err, input int hold,
                              input logic [31:0] exp_data, input bit exp_err, input int exp_lat,
                              input bit exp_to, input int exp_wr, input int exp_rd);
    vec_t v;
    v.op = op; v.data = data; v.rdata = rdata;
    v.w_aw = w_aw; v.w_dw = w_dw; v.r_aw = r_aw; v.r_dw = r_dw;
    v.w_err = w_err; v.r_err = r_err; v.hold = hold;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_to = exp_to; v.exp_wr = exp_wr; v.exp_rd = exp_rd;
    return v;
  endfunction

  // Called right after a negedge; returns right after a negedge.
  task automatic do_cmd(input vec_t v, input int idx, input bit keep_valid);
    int   cyc, aw_left, dw_left, phase, low_run, nwr, nrd, guard;
    bit   in_addr, err_now, err_first, to_exp, got;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    sb.push_back('{v.exp_data, v.exp_err, v.exp_lat, v.exp_to, v.exp_wr, v.exp_rd});
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge HCLK);
      guard++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      void'(sb.pop_back());
      return;
    end
    @(posedge HCLK);
    cyc = 0; phase = 0; in_addr = 0; low_run = 0; to_exp = 0;
    nwr = 0; nrd = 0; got = 0; aw_left = 0; dw_left = 0; err_now = 0; err_first = 0;
    while (!got && cyc < 60) begin
      @(negedge HCLK);
      cyc++;
      if (cyc == 1 && !keep_valid) cmd_valid = 1'b0;
      check("timeout_track", 32'(timeout), 32'(to_exp));
      if (rsp_valid) begin
        got = 1; HREADY = 1'b1; HRESP = 1'b0;
      end else if (phase != 0) begin
        if (dw_left > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; HRDATA = 32'hBAD0_BAD0; dw_left--;
        end else if (err_now && !err_first) begin
          HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hBAD0_BAD0; err_first = 1;
        end else begin
          HREADY = 1'b1; HRESP = err_now;
          HRDATA = (phase == 2) ? v.rdata : 32'hBAD0_BAD0;
          check("htrans_data_phase", 32'(HTRANS), 32'd0);
          if (phase == 1) check("hwdata", HWDATA, v.data);
          phase = 0;
        end
      end else if (HTRANS == 2'b10) begin
        if (!in_addr) begin
          in_addr = 1;
          aw_left = HWRITE ? v.w_aw : v.r_aw;
          if (HWRITE) nwr++; else nrd++;
          check("haddr", HADDR, HWRITE ? WADDR : RADDR);
        end else begin
          check("haddr_hold", HADDR, HWRITE ? WADDR : RADDR);
        end
        if (aw_left > 0) begin
          HREADY = 1'b0; HRESP = 1'b0; aw_left--;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0; in_addr = 0;
          phase     = HWRITE ? 1 : 2;
          dw_left   = HWRITE ? v.w_dw : v.r_dw;
          err_now   = HWRITE ? v.w_err : v.r_err;
          err_first = 0;
        end
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
      end
      if (!got) begin
        if (!HREADY) low_run++; else low_run = 0;
        if (low_run >= TB_MAX_WAIT) to_exp = 1;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
      HREADY = 1'b1; HRESP = 1'b0; cmd_valid = 1'b0;
      return;
    end
    check("latency", 32'(cyc), 32'(e.lat));
    check("rsp_data", rsp_data, e.data);
    check("rsp_err", 32'(rsp_err), 32'(e.err));
    check("timeout_at_rsp", 32'(timeout), 32'(e.to));
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    check("write_count", 32'(nwr), 32'(e.wr));
    check("read_count", 32'(nrd), 32'(e.rd));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge HCLK);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", rsp_data, e.data);
      check("hold_rsp_err", 32'(rsp_err), 32'(e.err));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
    $display("[TB] cmd %0d op=%0d data=%h -> rsp=%h err=%0d to=%0d lat=%0d wr=%0d rd=%0d",
             idx, v.op, v.data, e.data, e.err, e.to, cyc, nwr, nrd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    //          op     data          rdata         waw wdw raw rdw we re hold exp_data      err lat to wr rd
    vecs[0]  = mk(2'b00, 32'h0000_1234, 32'h0ABC_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0ABC_0000, 0, 5,  0, 1, 1);
    vecs[1]  = mk(2'b00, 32'h1111_2222, 32'hDEAD_BEEF, 0, 0, 0, 3, 0, 0, 0, 32'hDEAD_BEEF, 0, 8,  0, 1, 1);
    vecs[2]  = mk(2'b01, 32'h0000_0055, 32'hA5A5_A5A5, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 1, 4,  0, 1, 0);
    vecs[3]  = mk(2'b01, 32'h0000_CAFE, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 3,  0, 1, 0);
    vecs[4]  = mk(2'b10, 32'h0000_0000, 32'h1357_2468, 0, 0, 0, 0, 0, 0, 0, 32'h1357_2468, 0, 3,  0, 0, 1);
    vecs[5]  = mk(2'b11, 32'h0000_0077, 32'h89AB_CDEF, 1, 0, 2, 0, 0, 0, 0, 32'h89AB_CDEF, 0, 8,  0, 1, 1);
    vecs[6]  = mk(2'b00, 32'h0000_0099, 32'h1234_5678, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0000, 1, 4,  0, 1, 0);
    vecs[7]  = mk(2'b00, 32'h0000_0042, 32'hFFFF_0000, 0, 0, 0, 0, 0, 1, 0, 32'h0000_0000, 1, 6,  0, 1, 1);
    vecs[8]  = mk(2'b10, 32'h0000_0000, 32'h0F0F_0F0F, 0, 0, 0, 2, 0, 1, 0, 32'h0000_0000, 1, 6,  0, 0, 1);
    vecs[9]  = mk(2'b00, 32'h3141_5926, 32'h2718_2818, 6, 0, 0, 0, 0, 0, 0, 32'h2718_2818, 0, 11, 1, 1, 1);
    vecs[10] = mk(2'b10, 32'h0000_0000, 32'h600D_F00D, 0, 0, 0, 0, 0, 0, 0, 32'h600D_F00D, 0, 3,  0, 0, 1);
    vecs[11] = mk(2'b00, 32'h0000_ABCD, 32'h00C0_FFEE, 0, 3, 3, 0, 0, 0, 0, 32'h00C0_FFEE, 0, 11, 0, 1, 1);

    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("const_hsize", 32'(HSIZE), 32'd2);
    check("const_hburst", 32'(HBURST), 32'd0);
    check("const_hmastlock", 32'(HMASTLOCK), 32'd0);
    check("const_hprot", 32'(HPROT), 32'd3);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_htrans", 32'(HTRANS), 32'd0);

    for (int i = 0; i < 12; i++) do_cmd(vecs[i], i, 1'b0);

    // Backpressure: response held 10 cycles while the next command waits.
    hv = mk(2'b00, 32'h0000_5A5A, 32'h0102_0304, 0, 0, 0, 0, 0, 0, 10, 32'h0102_0304, 0, 5, 0, 1, 1);
    do_cmd(hv, 12, 1'b1);
    hv.hold = 0;
    do_cmd(hv, 13, 1'b0);

    // Reset while the read address phase is outstanding.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 32'd0;
    check("rstseq_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge HCLK);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("rstseq_r_addr_htrans", 32'(HTRANS), 32'd2);
    check("rstseq_r_addr_haddr", HADDR, RADDR);
    HRESETn = 1'b0;
    HREADY  = 1'b0;
    @(negedge HCLK);
    check("rstseq_htrans", 32'(HTRANS), 32'd0);
    check("rstseq_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstseq_haddr", HADDR, 32'd0);
    HRESETn = 1'b1;
    HREADY  = 1'b1;
    @(negedge HCLK);
    check("rstseq_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check("rstseq_no_rsp", 32'(rsp_valid), 32'd0);
      check("rstseq_bus_idle", 32'(HTRANS), 32'd0);
    end
    $display("[TB] reset during R_ADDR sequence done");
    do_cmd(vecs[0], 14, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
